rgb2raw_mosaic: RTL and testbench

Re-mosaics a 24-bit RGB pixel stream with VGA-style timing (VS/HS plus per-pixel read request) into a 10-bit single-channel Bayer RAW stream. It is the inverse of the RAW-to-RGB demosaic path. It sits between a frame source (test-pattern generator, frame buffer reader) and any consumer that expects D8M-style RAW pixels: the demosaic pipeline in loopback, or a RAW capture/compare stage. It also regenerates pixel X/Y coordinates and flags lines whose active length is wrong.

---
 rtl/rgb2raw_mosaic_pkg.sv | 26 ++
 rtl/rgb2raw_mosaic_if.sv | 30 +++
 rtl/rgb2raw_pos_counter.sv | 68 ++++++
 rtl/rgb2raw_mosaic.sv | 115 +++++++++++
 tb/tb_rgb2raw_mosaic.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rgb2raw_mosaic_pkg.sv
// Shared widths, Bayer site type and helpers for the RGB-to-RAW re-mosaic path.
// The helpers are the 8-to-10-bit component expansion and the site lookup for a pixel's {Y[0],X[0]} phase.
package rgb2raw_mosaic_pkg;

  localparam int RAW_W   = 10;
  localparam int COMP_W  = 8;
  localparam int COORD_W = 11;

  typedef enum logic [1:0] {SITE_R, SITE_G, SITE_B} site_e;

  // Replicating the top bits keeps full-scale white at full-scale RAW.
  function automatic logic [RAW_W-1:0] expand(input logic [COMP_W-1:0] c);
    return {c, c[COMP_W-1 -: 2]};
  endfunction

  function automatic site_e site_of(input logic [1:0] phase, input logic [1:0] red_phase);
    site_e site;
    site = SITE_G;
    if (phase == red_phase)
      site = SITE_R;
    else if (phase == (red_phase ^ 2'b11))
      site = SITE_B;
    return site;
  endfunction

endpackage

// File: rtl/rgb2raw_mosaic_if.sv
// Pixel bus of the re-mosaic block: RGB input side with VGA-style timing, and RAW output side.
interface rgb2raw_mosaic_if;
  import rgb2raw_mosaic_pkg::*;

  logic [COMP_W-1:0]  red;
  logic [COMP_W-1:0]  green;
  logic [COMP_W-1:0]  blue;
  logic               read_request;
  logic               vs;
  logic               hs;

  logic [RAW_W-1:0]   data;
  logic               dval;
  logic               fval;
  logic               lval;
  logic [COORD_W-1:0] x_cont;
  logic [COORD_W-1:0] y_cont;
  logic               line_err;

  modport master (
    output red, green, blue, read_request, vs, hs,
    input  data, dval, fval, lval, x_cont, y_cont, line_err
  );

  modport slave (
    input  red, green, blue, read_request, vs, hs,
    output data, dval, fval, lval, x_cont, y_cont, line_err
  );

endinterface

// File: rtl/rgb2raw_pos_counter.sv
// Regenerates pixel X/Y from read-request/vsync timing and flags lines of the wrong length.
// Also usable on the RAW-source side of the loopback.
module rgb2raw_pos_counter
  import rgb2raw_mosaic_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_request,
  input  logic               vs,
  output logic               accept,
  output logic [COORD_W-1:0] x_cnt,
  output logic [COORD_W-1:0] y_cnt,
  output logic               line_err
);

  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COORD_W-1:0] LINE_LEN  = COORD_W'(H_ACTIVE);

  logic req_d;
  logic vs_d;
  logic req_fall;
  logic vs_fall;

  assign accept   = read_request & vs;
  assign req_fall = req_d & ~read_request;
  assign vs_fall  = vs_d & ~vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      req_d <= read_request;
      vs_d  <= vs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      x_cnt <= '0;
    else if (req_fall)
      x_cnt <= '0;
    else if (accept && x_cnt != COORD_MAX)
      x_cnt <= x_cnt + COORD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      y_cnt <= '0;
    else if (!vs)
      y_cnt <= '0;
    else if (req_fall && y_cnt != COORD_MAX)
      y_cnt <= y_cnt + COORD_W'(1);
  end

  // Set has priority so an error on the last line of a frame is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_err <= 1'b0;
    else if (req_fall && vs && x_cnt != LINE_LEN)
      line_err <= 1'b1;
    else if (vs_fall)
      line_err <= 1'b0;
  end

endmodule

// File: rtl/rgb2raw_mosaic.sv
// Re-mosaics a 24-bit RGB stream into 10-bit Bayer RAW through a two-stage pipeline.
// Sync inputs are delayed to stay aligned with the RAW output.
module rgb2raw_mosaic
  import rgb2raw_mosaic_pkg::*;
#(
  parameter int         H_ACTIVE    = 640,
  parameter logic [1:0] BAYER_PHASE = 2'b01
) (
  input logic             clk,
  input logic             rst,
  rgb2raw_mosaic_if.slave bus
);

  logic               accept;
  logic               line_err;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;

  logic               s1_valid;
  logic [COMP_W-1:0]  s1_red;
  logic [COMP_W-1:0]  s1_green;
  logic [COMP_W-1:0]  s1_blue;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;
  logic [1:0]         s1_phase;

  site_e              s1_site;
  logic [RAW_W-1:0]   raw_sel;

  logic               s2_valid;
  logic [RAW_W-1:0]   s2_data;
  logic [COORD_W-1:0] s2_x;
  logic [COORD_W-1:0] s2_y;
  logic [1:0]         vs_pipe;
  logic [1:0]         hs_pipe;

  rgb2raw_pos_counter #(.H_ACTIVE(H_ACTIVE)) u_pos (
    .clk          (clk),
    .rst          (rst),
    .read_request (bus.read_request),
    .vs           (bus.vs),
    .accept       (accept),
    .x_cnt        (x_cnt),
    .y_cnt        (y_cnt),
    .line_err     (line_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_red   <= '0;
      s1_green <= '0;
      s1_blue  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_phase <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_red   <= bus.red;
        s1_green <= bus.green;
        s1_blue  <= bus.blue;
        s1_x     <= x_cnt;
        s1_y     <= y_cnt;
        s1_phase <= {y_cnt[0], x_cnt[0]};
      end
    end
  end

  always_comb begin
    s1_site = site_of(s1_phase, BAYER_PHASE);
    raw_sel = expand(s1_green);
    case (s1_site)
      SITE_R:  raw_sel = expand(s1_red);
      SITE_B:  raw_sel = expand(s1_blue);
      default: raw_sel = expand(s1_green);
    endcase
  end

  // Data and coordinates hold their last pixel while the output is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= raw_sel;
        s2_x    <= s1_x;
        s2_y    <= s1_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_pipe <= '0;
      hs_pipe <= '0;
    end else begin
      vs_pipe <= {vs_pipe[0], bus.vs};
      hs_pipe <= {hs_pipe[0], bus.hs};
    end
  end

  assign bus.data     = s2_data;
  assign bus.dval     = s2_valid;
  assign bus.fval     = vs_pipe[1];
  assign bus.lval     = hs_pipe[1];
  assign bus.x_cont   = s2_x;
  assign bus.y_cont   = s2_y;
  assign bus.line_err = line_err;

endmodule

// File: tb/tb_rgb2raw_mosaic.sv
// Directed bench for rgb2raw_mosaic: default-phase DUT plus a phase-00 DUT fed the same stimulus.
module tb_rgb2raw_mosaic;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [9:0] exp_def [2][2];
  logic [9:0] exp_ph0 [2][2];

  rgb2raw_mosaic_if bus0 ();
  rgb2raw_mosaic_if bus1 ();

  assign bus1.red          = bus0.red;
  assign bus1.green        = bus0.green;
  assign bus1.blue         = bus0.blue;
  assign bus1.read_request = bus0.read_request;
  assign bus1.vs           = bus0.vs;
  assign bus1.hs           = bus0.hs;

  rgb2raw_mosaic dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  rgb2raw_mosaic #(.BAYER_PHASE(2'b00)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus0.read_request = 1'b0;
      bus0.hs = 1'b0;
      step();
      check_output("idle_dval", 32'(bus0.dval), 32'd0);
    end
  endtask

  // One line of len accepted pixels followed by a single idle cycle.
  task automatic run_line(input int len, input int y, input logic err_after, input string tag);
    int         xe;
    logic       xb;
    logic       yb;
    logic [9:0] last0;
    logic [9:0] last1;
    last0 = '0;
    last1 = '0;
    yb = y[0];
    for (int j = 0; j <= len; j++) begin
      bus0.read_request = (j < len);
      bus0.hs = (j < len);
      step();
      if (j == 0) begin
        check_output({tag, "_latency_dval"}, 32'(bus0.dval), 32'd0);
        check_output({tag, "_lval_delay"}, 32'(bus0.lval), 32'd0);
      end else begin
        xe = (j - 1 > 2047) ? 2047 : j - 1;
        xb = xe[0];
        last0 = exp_def[yb][xb];
        last1 = exp_ph0[yb][xb];
        check_output({tag, "_dval"}, 32'(bus0.dval), 32'd1);
        check_output({tag, "_x"}, 32'(bus0.x_cont), 32'(xe));
        check_output({tag, "_y"}, 32'(bus0.y_cont), 32'(y));
        check_output({tag, "_data"}, 32'(bus0.data), 32'(last0));
        check_output({tag, "_data_ph0"}, 32'(bus1.data), 32'(last1));
      end
      if (j == 1)
        check_output({tag, "_lval"}, 32'(bus0.lval), 32'd1);
    end
    bus0.read_request = 1'b0;
    bus0.hs = 1'b0;
    step();
    check_output({tag, "_end_dval"}, 32'(bus0.dval), 32'd0);
    check_output({tag, "_hold_data"}, 32'(bus0.data), 32'(last0));
    check_output({tag, "_hold_data_ph0"}, 32'(bus1.data), 32'(last1));
    check_output({tag, "_line_err"}, 32'(bus0.line_err), 32'(err_after));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, 32'(bus0.data), 32'd0);
    check_output({tag, "_dval"}, 32'(bus0.dval), 32'd0);
    check_output({tag, "_fval"}, 32'(bus0.fval), 32'd0);
    check_output({tag, "_lval"}, 32'(bus0.lval), 32'd0);
    check_output({tag, "_x"}, 32'(bus0.x_cont), 32'd0);
    check_output({tag, "_y"}, 32'(bus0.y_cont), 32'd0);
    check_output({tag, "_line_err"}, 32'(bus0.line_err), 32'd0);
    check_output({tag, "_data_ph0"}, 32'(bus1.data), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    // RGB=(FF,80,00): red 3FF, green 202, blue 000
    exp_def[0][0] = 10'h202;
    exp_def[0][1] = 10'h3FF;
    exp_def[1][0] = 10'h000;
    exp_def[1][1] = 10'h202;
    exp_ph0[0][0] = 10'h3FF;
    exp_ph0[0][1] = 10'h202;
    exp_ph0[1][0] = 10'h202;
    exp_ph0[1][1] = 10'h000;

    rst = 1'b1;
    bus0.red = 8'hFF;
    bus0.green = 8'h80;
    bus0.blue = 8'h00;
    bus0.read_request = 1'b0;
    bus0.vs = 1'b0;
    bus0.hs = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    idle(3);
    bus0.vs = 1'b1;
    step();
    check_output("fval_delay1", 32'(bus0.fval), 32'd0);
    step();
    check_output("fval_delay2", 32'(bus0.fval), 32'd1);
    idle(2);

    for (int l = 0; l < 4; l++) begin
      run_line(640, l, 1'b0, "frame_line");
      idle(3);
    end

    bus0.vs = 1'b0;
    idle(3);
    check_output("fval_low", 32'(bus0.fval), 32'd0);

    // Requests while vsync is low must be dropped
    for (int i = 0; i < 10; i++) begin
      bus0.read_request = 1'b1;
      step();
      check_output("vs_low_dval", 32'(bus0.dval), 32'd0);
    end
    idle(3);
    bus0.vs = 1'b1;
    idle(3);
    run_line(640, 0, 1'b0, "after_drop");
    idle(3);

    run_line(639, 1, 1'b1, "short_line");
    idle(3);
    check_output("short_err_sticky", 32'(bus0.line_err), 32'd1);
    run_line(640, 2, 1'b1, "after_short");
    idle(3);
    bus0.vs = 1'b0;
    step();
    check_output("err_clear_vs_fall", 32'(bus0.line_err), 32'd0);
    idle(3);
    bus0.vs = 1'b1;
    idle(3);

    // Reset asserted mid-cycle during a line at X=300
    for (int i = 0; i < 300; i++) begin
      bus0.read_request = 1'b1;
      bus0.hs = 1'b1;
      step();
    end
    check_output("pre_reset_x", 32'(bus0.x_cont), 32'd298);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus0.read_request = 1'b0;
    bus0.hs = 1'b0;
    step();
    rst = 1'b0;
    idle(3);
    run_line(640, 0, 1'b0, "post_reset");
    idle(3);

    run_line(2100, 1, 1'b1, "saturate");
    check_output("saturate_x_hold", 32'(bus0.x_cont), 32'd2047);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
